// File: rtl/star_bbox_scanner_if.sv
// star_bbox_scanner_if
//   Read port of the shared frame memory used by star_bbox_scanner.
//   pixAddr : word address, y*X_RES + x (driven by the scanner)
//   pixVal  : pixel value returned a fixed number of cycles after pixAddr
//   modport master : the scanner side (drives the address)
//   modport slave  : the memory side (returns the data)
interface star_bbox_scanner_if #(
    parameter int ADDR_W = 12,
    parameter int COL_W  = 3
);
    logic [ADDR_W-1:0] pixAddr;
    logic [COL_W-1:0]  pixVal;

    modport master (output pixAddr, input pixVal);
    modport slave  (input pixAddr, output pixVal);
endinterface

// File: rtl/star_bbox_scanner.sv
// star_bbox_scanner
//   On a starFound pulse with seed (xIn, yIn) this block probes the frame
//   memory right then left along the seed row, then down then up along the
//   column at the row midpoint, and reports the star's bounding box.
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   starFound        start pulse; xIn/yIn sampled on the same edge
//   xIn, yIn         seed coordinates
//   mem (master)     pixAddr out / pixVal in, read latency RD_LATENCY
//   busy             high from the cycle after start until done
//   bboxFound        one-cycle done pulse
//   seedDark         seed pixel was not lit
//   mostLeft/Right   horizontal extent on the seed row
//   mostTop/Bottom   vertical extent on the midpoint column
//   midPix           (mostLeft + mostRight) >> 1
//
// Optional build macro BBOX_DIAG_EN adds bboxWidth, bboxHeight and
// probeCount (saturating count of probes issued in the last scan).
module star_bbox_scanner #(
    parameter int X_RES      = 60,
    parameter int Y_RES      = 60,
    parameter int XW         = 6,
    parameter int YW         = 6,
    parameter int ADDR_W     = 12,
    parameter int COL_W      = 3,
    parameter int THRESHOLD  = 0,
    parameter int RD_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       starFound,
    input  logic [XW-1:0]              xIn,
    input  logic [YW-1:0]              yIn,
    star_bbox_scanner_if.master        mem,
    output logic                       busy,
    output logic                       bboxFound,
    output logic                       seedDark,
    output logic [XW-1:0]              mostLeft,
    output logic [XW-1:0]              mostRight,
    output logic [YW-1:0]              mostTop,
    output logic [YW-1:0]              mostBottom,
    output logic [XW-1:0]              midPix
`ifdef BBOX_DIAG_EN
    ,
    output logic [XW:0]                bboxWidth,
    output logic [YW:0]                bboxHeight,
    output logic [15:0]                probeCount
`endif
);

    typedef enum logic [2:0] {
        IDLE, SEED, SCAN_R, SCAN_L, SCAN_D, SCAN_U, DONE
    } state_t;

    localparam int CW = 3;

    state_t            state;
    logic [CW-1:0]     wait_cnt;
    logic [YW-1:0]     y0;
    logic [ADDR_W-1:0] pix_addr;

    logic              in_seed, in_r, in_l, in_d, in_u;
    logic              eval, lit;
    logic [XW-1:0]     right_n, left_n, mid_n;
    logic [YW-1:0]     bottom_n, top_n;
    logic              need_r, need_l, need_d, need_u;
    logic              reach_l, reach_d, reach_u, row_done;
    logic [ADDR_W-1:0] next_addr;

    assign mem.pixAddr = pix_addr;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [XW-1:0] x,
                                                  input logic [YW-1:0] y);
        return ADDR_W'(y) * ADDR_W'(X_RES) + ADDR_W'(x);
    endfunction

    // Evaluation: the probe address went out at the edge that started the
    // probe; pixVal is sampled once the wait counter reaches RD_LATENCY+1.
    always_comb begin
        in_seed  = (state == SEED);
        in_r     = (state == SCAN_R);
        in_l     = (state == SCAN_L);
        in_d     = (state == SCAN_D);
        in_u     = (state == SCAN_U);
        eval     = (in_seed || in_r || in_l || in_d || in_u) &&
                   (wait_cnt == CW'(RD_LATENCY + 1));
        lit      = (mem.pixVal > COL_W'(THRESHOLD));

        right_n  = (in_r && lit) ? mostRight + XW'(1)  : mostRight;
        left_n   = (in_l && lit) ? mostLeft - XW'(1)   : mostLeft;
        bottom_n = (in_d && lit) ? mostBottom + YW'(1) : mostBottom;
        top_n    = (in_u && lit) ? mostTop - YW'(1)    : mostTop;
        mid_n    = XW'(({1'b0, left_n} + {1'b0, right_n}) >> 1);

        // Directions with nothing left to probe (image edge or dark
        // pixel) fall through to the next one on the same edge, so a
        // skipped direction costs no cycles.
        need_r   = (in_seed || in_r) && lit && (32'(right_n) < X_RES - 1);
        reach_l  = ((in_seed && lit) || in_r) && !need_r;
        need_l   = (reach_l || (in_l && lit)) && (left_n != '0);
        reach_d  = (reach_l || in_l) && !need_l;
        need_d   = (reach_d || (in_d && lit)) && (32'(bottom_n) < Y_RES - 1);
        reach_u  = (reach_d || in_d) && !need_d;
        need_u   = (reach_u || (in_u && lit)) && (top_n != '0);
        row_done = (in_seed || in_r || in_l) && !need_r && !need_l;

        next_addr = pix_addr;
        if (need_r)
            next_addr = addr_of(right_n + XW'(1), y0);
        else if (need_l)
            next_addr = addr_of(left_n - XW'(1), y0);
        else if (need_d)
            next_addr = addr_of(mid_n, bottom_n + YW'(1));
        else if (need_u)
            next_addr = addr_of(mid_n, top_n - YW'(1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            y0         <= '0;
            pix_addr   <= '0;
            busy       <= 1'b0;
            bboxFound  <= 1'b0;
            seedDark   <= 1'b0;
            mostLeft   <= '0;
            mostRight  <= '0;
            mostTop    <= '0;
            mostBottom <= '0;
            midPix     <= '0;
`ifdef BBOX_DIAG_EN
            bboxWidth  <= '0;
            bboxHeight <= '0;
            probeCount <= '0;
`endif
        end else if (starFound) begin
            state      <= SEED;
            wait_cnt   <= '0;
            y0         <= yIn;
            pix_addr   <= addr_of(xIn, yIn);
            busy       <= 1'b1;
            bboxFound  <= 1'b0;
            seedDark   <= 1'b0;
            mostLeft   <= xIn;
            mostRight  <= xIn;
            mostTop    <= yIn;
            mostBottom <= yIn;
            midPix     <= xIn;
`ifdef BBOX_DIAG_EN
            probeCount <= 16'd1;
`endif
        end else begin
            case (state)
                IDLE: begin
                end
                DONE: begin
                    bboxFound <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    if (!eval) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end else begin
                        wait_cnt   <= CW'(1);
                        mostRight  <= right_n;
                        mostLeft   <= left_n;
                        mostBottom <= bottom_n;
                        mostTop    <= top_n;
                        pix_addr   <= next_addr;
                        if (row_done)
                            midPix <= mid_n;
`ifdef BBOX_DIAG_EN
                        if ((need_r || need_l || need_d || need_u) &&
                            (probeCount != '1))
                            probeCount <= probeCount + 16'd1;
`endif
                        if (need_r)
                            state <= SCAN_R;
                        else if (need_l)
                            state <= SCAN_L;
                        else if (need_d)
                            state <= SCAN_D;
                        else if (need_u)
                            state <= SCAN_U;
                        else begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            bboxFound <= 1'b1;
                            seedDark  <= in_seed && !lit;
`ifdef BBOX_DIAG_EN
                            bboxWidth  <= {1'b0, right_n} - {1'b0, left_n} + (XW+1)'(1);
                            bboxHeight <= {1'b0, bottom_n} - {1'b0, top_n} + (YW+1)'(1);
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_star_bbox_scanner.sv
// tb_star_bbox_scanner
//   Two scanners (RD_LATENCY 1 and 3) share stimulus and a 60x60 image.
//   Table-driven scans plus hand-written restart and reset sequences.
module tb_star_bbox_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       starFound;
    logic [5:0] xIn, yIn;

    logic       busy1, bf1, dark1, busy3, bf3, dark3;
    logic [5:0] l1, r1, t1, b1, mid1, l3, r3, t3, b3, mid3;
`ifdef BBOX_DIAG_EN
    logic [6:0]  w1, h1, w3, h3;
    logic [15:0] pc1, pc3;
`endif

    star_bbox_scanner_if #(.ADDR_W(12), .COL_W(3)) m1 ();
    star_bbox_scanner_if #(.ADDR_W(12), .COL_W(3)) m3 ();

    star_bbox_scanner #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .resetn(resetn), .starFound(starFound), .xIn(xIn), .yIn(yIn),
        .mem(m1), .busy(busy1), .bboxFound(bf1), .seedDark(dark1),
        .mostLeft(l1), .mostRight(r1), .mostTop(t1), .mostBottom(b1), .midPix(mid1)
`ifdef BBOX_DIAG_EN
        , .bboxWidth(w1), .bboxHeight(h1), .probeCount(pc1)
`endif
    );

    star_bbox_scanner #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .resetn(resetn), .starFound(starFound), .xIn(xIn), .yIn(yIn),
        .mem(m3), .busy(busy3), .bboxFound(bf3), .seedDark(dark3),
        .mostLeft(l3), .mostRight(r3), .mostTop(t3), .mostBottom(b3), .midPix(mid3)
`ifdef BBOX_DIAG_EN
        , .bboxWidth(w3), .bboxHeight(h3), .probeCount(pc3)
`endif
    );

    // Frame memory with a 1-stage and a 3-stage read pipeline.
    logic [2:0] img [0:3599];
    logic [2:0] p1, p3a, p3b, p3c;
    bit         oob1 = 1'b0, oob3 = 1'b0;

    function automatic logic [2:0] rd(input logic [11:0] a);
        if (a < 12'd3600) return img[a];
        return 3'd0;
    endfunction

    always_ff @(posedge clk) begin
        p1  <= rd(m1.pixAddr);
        p3a <= rd(m3.pixAddr);
        p3b <= p3a;
        p3c <= p3b;
        if (m1.pixAddr > 12'd3599) oob1 <= 1'b1;
        if (m3.pixAddr > 12'd3599) oob3 <= 1'b1;
    end

    assign m1.pixVal = p1;
    assign m3.pixVal = p3c;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 3600; i++) img[i] = 3'd0;
    endtask

    task automatic fill(input int x0, input int x1, input int y0, input int y1,
                        input int v);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                img[y*60 + x] = 3'(v);
    endtask

    // Pulse starFound; returns #1 after the sampling edge.
    task automatic start(input int x, input int y);
        starFound = 1'b1;
        xIn = 6'(x);
        yIn = 6'(y);
        @(posedge clk);
        #1;
        starFound = 1'b0;
    endtask

    int lat [2];
    int pulses [2];
    int cl [2], cr [2], ct [2], cb [2], cm [2], cd [2], cby [2];

    // Watch both DUTs for up to budget cycles, capturing outputs at the
    // first bboxFound of each and counting every pulse.
    task automatic watch(input int budget);
        int last;
        for (int d = 0; d < 2; d++) begin
            lat[d] = -1;
            pulses[d] = 0;
        end
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (bf1) begin
                pulses[0]++;
                if (lat[0] < 0) begin
                    lat[0] = c; cl[0] = int'(l1); cr[0] = int'(r1); ct[0] = int'(t1);
                    cb[0] = int'(b1); cm[0] = int'(mid1); cd[0] = int'(dark1);
                    cby[0] = int'(busy1);
                end
            end
            if (bf3) begin
                pulses[1]++;
                if (lat[1] < 0) begin
                    lat[1] = c; cl[1] = int'(l3); cr[1] = int'(r3); ct[1] = int'(t3);
                    cb[1] = int'(b3); cm[1] = int'(mid3); cd[1] = int'(dark3);
                    cby[1] = int'(busy3);
                end
            end
            last = (lat[0] > lat[1]) ? lat[0] : lat[1];
            if (lat[0] >= 0 && lat[1] >= 0 && c > last + 3) break;
        end
    endtask

    typedef struct {
        int rx0, rx1, ry0, ry1, val;
        int sx, sy;
        int l, r, t, b, mid, dark, probes;
    } vec_t;

    vec_t vecs [7];
    int   lt;
    string nm;

    initial begin
        // rect x0..x1, y0..y1, value | seed | expected L R T B mid dark probes
        vecs[0] = '{ 9, 11,  9, 11, 5, 10, 10,   9, 11,  9, 11, 10, 0,  9};
        vecs[1] = '{20, 22, 20, 22, 7,  5,  5,   5,  5,  5,  5,  5, 1,  1};
        vecs[2] = '{57, 59, 57, 59, 3, 58, 58,  57, 59, 57, 59, 58, 0,  7};
        vecs[3] = '{ 0,  2,  0,  2, 1,  1,  1,   0,  2,  0,  2,  1, 0,  7};
        vecs[4] = '{30, 30, 30, 30, 4, 30, 30,  30, 30, 30, 30, 30, 0,  5};
        vecs[5] = '{20, 25, 40, 44, 2, 21, 42,  20, 25, 40, 44, 22, 0, 14};
        vecs[6] = '{ 0, 59, 50, 52, 6, 59, 51,   0, 59, 50, 52, 29, 0, 64};

        clear_img();
        resetn = 1'b0;
        starFound = 1'b0;
        xIn = '0;
        yIn = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy1), 0);
        chk("reset_bbox_found", int'(bf1), 0);
        chk("reset_addr", int'(m1.pixAddr), 0);
        chk("reset_bounds", int'({l1, r1, t1, b1, mid1, dark1}), 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            clear_img();
            fill(vecs[i].rx0, vecs[i].rx1, vecs[i].ry0, vecs[i].ry1, vecs[i].val);
            start(vecs[i].sx, vecs[i].sy);
            chk($sformatf("v%0d_busy_after_start", i), int'(busy1), 1);
            chk($sformatf("v%0d_right_cleared_to_seed", i), int'(r1), vecs[i].sx);
            watch(400);
            for (int d = 0; d < 2; d++) begin
                lt = (d == 0) ? 1 : 3;
                nm = $sformatf("v%0d_lat%0d", i, lt);
                chk({nm, "_latency"}, lat[d], 1 + vecs[i].probes * (lt + 1));
                chk({nm, "_pulses"}, pulses[d], 1);
                chk({nm, "_left"}, cl[d], vecs[i].l);
                chk({nm, "_right"}, cr[d], vecs[i].r);
                chk({nm, "_top"}, ct[d], vecs[i].t);
                chk({nm, "_bottom"}, cb[d], vecs[i].b);
                chk({nm, "_mid"}, cm[d], vecs[i].mid);
                chk({nm, "_seed_dark"}, cd[d], vecs[i].dark);
                chk({nm, "_busy_at_done"}, cby[d], 0);
            end
        end

        // Restart: the 1-latency scanner is in SCAN_D (column 10, row 11)
        // when a new seed arrives on a lone pixel at (30,30).
        clear_img();
        fill(9, 11, 9, 11, 5);
        fill(30, 30, 30, 30, 5);
        start(10, 10);
        pulses[0] = 0;
        pulses[1] = 0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (bf1) pulses[0]++;
            if (bf3) pulses[1]++;
        end
        chk("restart_in_scan_d_addr", int'(m1.pixAddr), 11*60 + 10);
        chk("restart_no_early_done", pulses[0] + pulses[1], 0);
        start(30, 30);
        watch(200);
        for (int d = 0; d < 2; d++) begin
            lt = (d == 0) ? 1 : 3;
            nm = $sformatf("restart_lat%0d", lt);
            chk({nm, "_latency"}, lat[d], 1 + 5 * (lt + 1));
            chk({nm, "_pulses"}, pulses[d], 1);
            chk({nm, "_bounds"}, (cl[d] << 18) | (cr[d] << 12) | (ct[d] << 6) | cb[d],
                (30 << 18) | (30 << 12) | (30 << 6) | 30);
            chk({nm, "_mid"}, cm[d], 30);
            chk({nm, "_seed_dark"}, cd[d], 0);
        end

        // Reset while both scanners are in SCAN_R; starFound asserted on
        // the same edge must lose to reset.
        clear_img();
        fill(9, 11, 9, 11, 5);
        start(10, 10);
        repeat (5) @(posedge clk);
        #1;
        chk("rst_pre_scan_r_addr_lat1", int'(m1.pixAddr), 10*60 + 12);
        chk("rst_pre_scan_r_addr_lat3", int'(m3.pixAddr), 10*60 + 11);
        resetn = 1'b0;
        starFound = 1'b1;
        xIn = 6'd40;
        yIn = 6'd40;
        @(posedge clk);
        #1;
        starFound = 1'b0;
        chk("rst_busy_lat1", int'(busy1), 0);
        chk("rst_busy_lat3", int'(busy3), 0);
        chk("rst_addr_lat1", int'(m1.pixAddr), 0);
        chk("rst_addr_lat3", int'(m3.pixAddr), 0);
        chk("rst_outputs_lat1", int'({bf1, dark1, l1, r1, t1, b1, mid1}), 0);
        chk("rst_outputs_lat3", int'({bf3, dark3, l3, r3, t3, b3, mid3}), 0);
        resetn = 1'b1;
        watch(80);
        chk("rst_no_done_lat1", pulses[0], 0);
        chk("rst_no_done_lat3", pulses[1], 0);
        chk("rst_idle_busy", int'(busy1 | busy3), 0);

        chk("addr_in_range_lat1", int'(oob1), 0);
        chk("addr_in_range_lat3", int'(oob3), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/star_bbox_scanner.md
Name: star_bbox_scanner

Overview:
- Parametrised successor to the single-direction top/bottom star search.
- On a star-found pulse with a seed (x,y), it scans the image memory in four directions and reports the star's full bounding box: left, right, top, bottom.
- Order: right then left along the seed row; down then up along the column at the row midpoint.
- Drives a shared read-only frame memory through an address/data port with parametrised read latency.
- Sits between the star detector and the star-marking/drawing stage.

Parameters:
- X_RES, 60, image width in pixels.
- Y_RES, 60, image height in pixels.
- XW, 6, x coordinate width (must satisfy 2^XW >= X_RES).
- YW, 6, y coordinate width (must satisfy 2^YW >= Y_RES).
- ADDR_W, 12, memory address width (must satisfy 2^ADDR_W >= X_RES*Y_RES).
- COL_W, 3, pixel value width.
- THRESHOLD, 0, a pixel is lit iff pixVal > THRESHOLD.
- RD_LATENCY, 1, clock cycles from pixAddr to valid pixVal (1..4).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  synchronous active-low reset.
- starFound  in  1  single-cycle start pulse; xIn/yIn are sampled on the same edge.
- xIn  in  XW  seed x coordinate.
- yIn  in  YW  seed y coordinate.
- pixAddr  out  ADDR_W  memory read address, equal to y*X_RES + x.
- pixVal  in  COL_W  memory read data, valid RD_LATENCY cycles after the address.
- busy  out  1  high from the cycle after start until done.
- bboxFound  out  1  one-cycle done pulse.
- seedDark  out  1  set with bboxFound when the seed pixel was not lit.
- mostLeft  out  XW  leftmost lit x on the seed row.
- mostRight  out  XW  rightmost lit x on the seed row.
- mostTop  out  YW  topmost lit y on the midpoint column.
- mostBottom  out  YW  bottommost lit y on the midpoint column.
- midPix  out  XW  (mostLeft + mostRight) >> 1.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: busy, bboxFound, seedDark, the four bounds, midPix, pixAddr.
  - Reset beats starFound when both are active.
- States: IDLE, SEED, SCAN_R, SCAN_L, SCAN_D, SCAN_U, DONE.
- Start / restart:
  - starFound=1 latches xIn/yIn and enters SEED from any state. An in-progress scan is abandoned.
  - Bound outputs are cleared to the seed coordinates on the same edge.
- Probe timing:
  - Each probe drives pixAddr for one issue cycle, then waits RD_LATENCY cycles and evaluates pixVal.
  - A probe therefore costs RD_LATENCY+1 cycles.
  - pixAddr is held stable for the whole probe.
- SEED: probe (x0,y0).
  - Dark: seedDark=1, all bounds = seed, go to DONE.
  - Lit: go to SCAN_R.
- SCAN_R: probe x+1 on row y0.
  - Lit: mostRight = x+1 and repeat.
  - Dark: go to SCAN_L.
  - At x = X_RES-1 there is no probe; go directly to SCAN_L.
- SCAN_L: same as SCAN_R, decrementing x; updates mostLeft. At x = 0, no probe.
- Entering SCAN_D: midPix is registered from an XW+1-bit sum shifted right by 1. No overflow.
- SCAN_D: probe rows y+1 downward on column midPix; updates mostBottom. Stops at a dark pixel or at Y_RES-1.
- SCAN_U: probe rows y-1 upward from y0; updates mostTop. Stops at a dark pixel or at 0.
  - The midPix column at y0 is known lit, because it lies between two lit pixels on a convex star.
- DONE:
  - bboxFound high for exactly one cycle, then state returns to IDLE.
  - Outputs hold until the next starFound or reset.
  - busy falls in the same cycle that bboxFound rises.
- Latency: bboxFound rises 1 + N*(RD_LATENCY+1) cycles after the starFound edge, where N = number of probes issued, seed probe included.
- Coordinates never wrap; there are no out-of-range addresses.

Optional Feature:
- Macro: BBOX_DIAG_EN.
- Defined:
  - Extra outputs bboxWidth (XW+1) = mostRight - mostLeft + 1 and bboxHeight (YW+1) = mostBottom - mostTop + 1.
  - Both are registered, valid when bboxFound asserts, and reset to 0.
  - Extra output probeCount (16 bits) = probes issued in the last scan, saturating at 16'hFFFF.
- Undefined: these ports do not exist; all other behaviour is identical.

Test Plan:
- 3x3 lit square centred (10,10), seed (10,10), RD_LATENCY=1:
  - Bounds L=9, R=11, T=9, B=11, midPix=10, seedDark=0.
  - 9 probes; bboxFound 19 cycles after start.
- Same image, RD_LATENCY=3: identical bounds; bboxFound 37 cycles after start.
- Dark seed (5,5) → bboxFound after 1+(RD_LATENCY+1) cycles, seedDark=1, all bounds 5, midPix 5.
- Star touching corner, lit (57..59, 57..59), seed (58,58):
  - R=59 and B=59 with no probe at x=60 or y=60.
  - pixAddr never exceeds 3599.
- Star at origin, lit (0..2, 0..2), seed (1,1): L=0, T=0; no probe at x or y = -1.
- starFound re-asserted mid-SCAN_D with a new seed (30,30) on a 1x1 star:
  - Old scan is abandoned; a single bboxFound is produced.
  - Bounds all 30 (L=R=30, T=B=30), midPix=30.
- resetn=0 during SCAN_R:
  - Next cycle all outputs are 0 and the state is IDLE.
  - No bboxFound is produced until a new starFound.
